// File: rtl/isb_pf_arbiter.sv
// isb_pf_arbiter: shares one memory request port between demand accesses and
// prefetch candidates from the ISB stream predictor. Candidates wait in a small
// compacting queue (slot 0 oldest). Duplicate candidates are dropped, and queued
// entries already covered by a demand are squashed. Demands win arbitration,
// except that after STARVE_MAX back-to-back demand grants with work queued, one
// prefetch is forced through.
module isb_pf_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int QDEPTH     = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      dem_v,
    input  logic [ADDR_W-1:0]         dem_addr,
    output logic                      dem_rdy,
    input  logic                      pf_v,
    input  logic [ADDR_W-1:0]         pf_addr,
    output logic                      pf_drop,
    output logic                      mem_v,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_is_pf,
    input  logic                      mem_rdy,
    output logic [$clog2(QDEPTH):0]   q_count
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] QFULL  = CNT_W'(QDEPTH);
    localparam logic [ST_W-1:0]  ST_LIM = ST_W'(STARVE_MAX);

    // Queue storage and occupancy
    logic [ADDR_W-1:0] q_addr_q [QDEPTH];
    logic [ADDR_W-1:0] q_addr_d [QDEPTH];
    logic [CNT_W-1:0]  q_cnt_q, q_cnt_d;

    // Output request register
    logic              mem_v_q, mem_v_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_is_pf_q, mem_is_pf_d;

    // Drop pulse and starvation counter
    logic              pf_drop_q, pf_drop_d;
    logic [ST_W-1:0]   starve_q, starve_d;

    // Arbitration and queue bookkeeping
    logic              slot_free;
    logic              q_nonempty;
    logic              force_pf;
    logic              dem_rdy_w;
    logic              dem_grant;
    logic              pf_grant;
    logic              sq_hit;
    logic [CNT_W-1:0]  sq_idx;
    logic              pf_hit_q;
    logic              rm_en;
    logic [CNT_W-1:0]  rm_idx;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic              held;
    logic              pf_reject;
    logic              pf_ins;
    logic [CNT_W-1:0]  cnt_mid;
    logic [CNT_W-1:0]  cnt_after_sq;

    // Saturating increment for the starvation counter.
    function automatic logic [ST_W-1:0] starve_inc(input logic [ST_W-1:0] v);
        if (v == ST_LIM) begin
            return v;
        end
        return v + ST_W'(1);
    endfunction

    // Grant decision: demands first unless the starvation guard forces a prefetch.
    always_comb begin
        slot_free  = !mem_v_q || mem_rdy;
        q_nonempty = (q_cnt_q != '0);
        force_pf   = (starve_q == ST_LIM) && q_nonempty;
        // dem_rdy must not look at dem_v, so it is built from state and mem_rdy only.
        dem_rdy_w  = slot_free && !force_pf;
        dem_grant  = dem_v && dem_rdy_w;
        pf_grant   = slot_free && !dem_grant && q_nonempty;
        held       = mem_v_q && !mem_rdy;
        load_en    = dem_grant || pf_grant;
        load_addr  = dem_grant ? dem_addr : q_addr_q[0];
    end

    // Associative lookups against the valid (pre-removal) queue contents.
    always_comb begin
        sq_hit   = 1'b0;
        sq_idx   = '0;
        pf_hit_q = 1'b0;
        // Scan high to low so the oldest matching slot wins the squash index.
        for (int i = QDEPTH - 1; i >= 0; i--) begin
            if (CNT_W'(i) < q_cnt_q) begin
                if (q_addr_q[i] == dem_addr) begin
                    sq_hit = 1'b1;
                    sq_idx = CNT_W'(i);
                end
                if (q_addr_q[i] == pf_addr) begin
                    pf_hit_q = 1'b1;
                end
            end
        end
    end

    // Candidate acceptance and single removal (grant from slot 0 or squash).
    always_comb begin
        rm_en  = pf_grant || (dem_grant && sq_hit);
        rm_idx = pf_grant ? '0 : sq_idx;
        // Fullness uses the count before this cycle's removal on purpose.
        pf_reject = pf_hit_q
                 || (held && (pf_addr == mem_addr_q))
                 || (load_en && (pf_addr == load_addr))
                 || (q_cnt_q == QFULL);
        pf_ins    = pf_v && !pf_reject;
        pf_drop_d = pf_v && pf_reject;
    end

    // Next queue contents: compact over the removed slot, then append.
    always_comb begin
        cnt_mid = q_cnt_q - CNT_W'(rm_en);
        for (int i = 0; i < QDEPTH; i++) begin
            q_addr_d[i] = q_addr_q[i];
        end
        for (int i = 0; i < QDEPTH - 1; i++) begin
            if (rm_en && (CNT_W'(i) >= rm_idx)) begin
                q_addr_d[i] = q_addr_q[i+1];
            end
        end
        for (int i = 0; i < QDEPTH; i++) begin
            if (pf_ins && (CNT_W'(i) == cnt_mid)) begin
                q_addr_d[i] = pf_addr;
            end
        end
        q_cnt_d = cnt_mid + CNT_W'(pf_ins);
    end

    // Starvation counter: counts demand grants that leave prefetch work waiting.
    always_comb begin
        cnt_after_sq = q_cnt_q - CNT_W'(dem_grant && sq_hit);
        starve_d     = starve_q;
        if (dem_grant) begin
            starve_d = (cnt_after_sq != '0) ? starve_inc(starve_q) : '0;
        end else if (pf_grant) begin
            starve_d = '0;
        end
    end

    // Output register: reload only when the slot frees, otherwise hold steady.
    always_comb begin
        mem_v_d     = mem_v_q;
        mem_addr_d  = mem_addr_q;
        mem_is_pf_d = mem_is_pf_q;
        if (slot_free) begin
            mem_v_d = load_en;
            if (load_en) begin
                mem_addr_d  = load_addr;
                mem_is_pf_d = pf_grant;
            end
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_v_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_is_pf_q <= 1'b0;
            pf_drop_q   <= 1'b0;
            q_cnt_q     <= '0;
            starve_q    <= '0;
        end else begin
            mem_v_q     <= mem_v_d;
            mem_addr_q  <= mem_addr_d;
            mem_is_pf_q <= mem_is_pf_d;
            pf_drop_q   <= pf_drop_d;
            q_cnt_q     <= q_cnt_d;
            starve_q    <= starve_d;
        end
    end

    // Queue payload; validity comes from q_cnt_q, so no reset is needed here.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            q_addr_q[i] <= q_addr_d[i];
        end
    end

    assign dem_rdy   = dem_rdy_w;
    assign pf_drop   = pf_drop_q;
    assign mem_v     = mem_v_q;
    assign mem_addr  = mem_addr_q;
    assign mem_is_pf = mem_is_pf_q;
    assign q_count   = q_cnt_q;

endmodule
